// File: rtl/mau_pkg.sv
// Shared types and helpers for the load/store stage: FSM states, funct3 codes,
// rmem one-hot encodings and byte-lane masks.
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RESP = 2'd1,
    RMW_MERGE = 2'd2
  } mau_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [4:0] RMEM_LB  = 5'b00001;
  localparam logic [4:0] RMEM_LH  = 5'b00010;
  localparam logic [4:0] RMEM_LW  = 5'b00100;
  localparam logic [4:0] RMEM_LBU = 5'b01000;
  localparam logic [4:0] RMEM_LHU = 5'b10000;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  function automatic logic [4:0] rmem_onehot(input logic [2:0] f3);
    case (f3)
      F3_B:    return RMEM_LB;
      F3_H:    return RMEM_LH;
      F3_W:    return RMEM_LW;
      F3_BU:   return RMEM_LBU;
      F3_HU:   return RMEM_LHU;
      default: return 5'b00000;
    endcase
  endfunction

  // Sub-word lanes never cross the word: a halfword picks its half by a[1] only.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mau_align.sv
// Combinational lane logic: extracts/extends a load result from the memory word
// and merges sub-word store data into the word read back for read-modify-write.
module mau_align
  import mau_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] load_data,
  input  logic [15:0] wdata,
  output logic [31:0] ld_result,
  output logic [31:0] st_merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  lanes;
  logic [31:0] bit_mask;
  logic [31:0] rep_data;

  always_comb begin
    byte_v = 8'(load_data >> {addr_lo, 3'b000});
    half_v = addr_lo[1] ? load_data[31:16] : load_data[15:0];
    case (funct3)
      F3_B:    ld_result = {{24{byte_v[7]}}, byte_v};
      F3_H:    ld_result = {{16{half_v[15]}}, half_v};
      F3_BU:   ld_result = {24'd0, byte_v};
      F3_HU:   ld_result = {16'd0, half_v};
      default: ld_result = load_data;
    endcase
  end

  // Replicate the store data across the word, then keep only the addressed lanes.
  always_comb begin
    lanes    = lane_mask(funct3[1:0], addr_lo);
    bit_mask = '0;
    for (int i = 0; i < 4; i++) begin
      bit_mask[8*i +: 8] = {8{lanes[i]}};
    end
    rep_data  = (funct3[1:0] == 2'd0) ? {4{wdata[7:0]}} : {2{wdata}};
    st_merged = (load_data & ~bit_mask) | (rep_data & bit_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: loads return a registered writeback 2 edges after the request; SB/SH
// read-modify-write in 2 cycles, stall=1 on accept only. Option: MAU_MISALIGN_TRAP_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              stall,
  output logic [3:0]        wmem,
  output logic [4:0]        rmem,
  output logic [31:0]       mem_addr,
  output logic [31:0]       store_data,
  input  logic [31:0]       load_data,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [31:0]       wb_data
`ifdef MAU_MISALIGN_TRAP_EN
  ,
  output logic              misalign,
  output logic [ADDR_W-1:0] misalign_addr
`endif
);

  mau_state_t        state;
  logic [ADDR_W-1:0] ctx_addr;
  logic [2:0]        ctx_funct3;
  logic [RD_W-1:0]   ctx_rd;
  logic [15:0]       ctx_wdata;

  logic        is_load, is_store, f3_ok, misal, legal, accept, multi_cycle;
  logic        stall_c;
  logic [3:0]  wmem_c;
  logic [4:0]  rmem_c;
  logic [31:0] store_data_c, mem_addr_c;
  logic [31:0] ld_result, st_merged;

  mau_align u_align (
    .funct3    (ctx_funct3),
    .addr_lo   (ctx_addr[1:0]),
    .load_data (load_data),
    .wdata     (ctx_wdata),
    .ld_result (ld_result),
    .st_merged (st_merged)
  );

  always_comb begin
    is_load  = req_load;
    is_store = req_store & ~req_load;
    f3_ok    = is_load ? load_f3_ok(req_funct3) : store_f3_ok(req_funct3);
    misal    = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
    misal = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
`endif
    legal       = (state == IDLE) && req_valid && (is_load || is_store) && f3_ok;
    accept      = legal && !misal;
    multi_cycle = is_load || (req_funct3 != F3_W);
  end

  always_comb begin
    wmem_c       = '0;
    rmem_c       = '0;
    stall_c      = 1'b0;
    store_data_c = req_wdata;
    mem_addr_c   = 32'(req_addr >> 2);
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_load) begin
            rmem_c  = rmem_onehot(req_funct3);
            stall_c = 1'b1;
          end else if (req_funct3 == F3_W) begin
            wmem_c = 4'b1111;
          end else begin
            rmem_c  = RMEM_LW;
            stall_c = 1'b1;
          end
        end
      end
      LOAD_RESP: mem_addr_c = 32'(ctx_addr >> 2);
      RMW_MERGE: begin
        mem_addr_c   = 32'(ctx_addr >> 2);
        wmem_c       = lane_mask(ctx_funct3[1:0], ctx_addr[1:0]);
        store_data_c = st_merged;
      end
      default: ;
    endcase
  end

  // Strobes are forced quiet while reset is asserted, even if a request is presented.
  assign wmem       = rst_n ? wmem_c  : 4'd0;
  assign rmem       = rst_n ? rmem_c  : 5'd0;
  assign stall      = rst_n ? stall_c : 1'b0;
  assign mem_addr   = mem_addr_c;
  assign store_data = store_data_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      ctx_addr   <= '0;
      ctx_funct3 <= '0;
      ctx_rd     <= '0;
      ctx_wdata  <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && multi_cycle) begin
            ctx_addr   <= req_addr;
            ctx_funct3 <= req_funct3;
            ctx_rd     <= req_rd;
            ctx_wdata  <= req_wdata[15:0];
            state      <= is_load ? LOAD_RESP : RMW_MERGE;
          end
        end
        LOAD_RESP: begin
          wb_valid <= 1'b1;
          wb_rd    <= ctx_rd;
          wb_data  <= ld_result;
          state    <= IDLE;
        end
        RMW_MERGE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef MAU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= legal && misal;
      if (legal && misal) misalign_addr <= req_addr;
    end
  end
`endif

endmodule
